count_ctrl: RTL

- Sequencer for the frequency-count datapath of the Huffman encoder.
- Accepts a stream of 4-bit symbols and packs up to 256 of them into the 1024-bit character buffer. It then releases the count unit from reset, raises input_over and waits for count_over.
- It captures the 130-bit frequency vector, checks it against its own tally, and hands it downstream to tree construction over a valid/ready handshake.

---
 rtl/count_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/count_ctrl.sv
// Frequency-count sequencer: packs a symbol block into the count unit's character
// buffer, runs the count unit, checks its frequency vector and hands it downstream.
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   S_IDLE  | buffer cleared to pad, waiting for the first symbol of a block
//   S_FILL  | accepting symbols into consecutive buffer slots
//   S_START | one cycle: count unit leaves reset, input_over raised
//   S_WAIT  | waiting for count_over under a timeout
//   S_HOLD  | frequency vector offered downstream until accepted
module count_ctrl #(
    parameter int               SYM_W   = 4,
    parameter int               N_SYM   = 256,
    parameter int               N_CLASS = 10,
    parameter int               FREQ_W  = 13,
    parameter int               TIMEOUT = 1024,
    parameter logic [SYM_W-1:0] PAD_SYM = 4'hF
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [SYM_W-1:0]                sym_in,
    input  logic                            sym_valid,
    input  logic                            sym_last,
    output logic                            sym_ready,
    output logic                            cnt_nRST,
    output logic                            cnt_input_over,
    output logic [SYM_W*N_SYM-1:0]          cnt_char,
    input  logic [N_CLASS*FREQ_W-1:0]       cnt_freq,
    input  logic                            cnt_over,
    output logic [N_CLASS*FREQ_W-1:0]       freq_out,
    output logic                            freq_valid,
    input  logic                            freq_ready,
    output logic [$clog2(N_SYM+1)-1:0]      n_sym,
    output logic                            busy,
    output logic                            err_sum,
    output logic                            err_timeout
);

    localparam int NSYM_W = $clog2(N_SYM + 1);
    localparam int SLOT_W = $clog2(N_SYM);
    localparam int TMO_W  = $clog2(TIMEOUT);

    localparam logic [NSYM_W-1:0] LAST_N   = NSYM_W'(N_SYM - 1);
    localparam logic [SLOT_W-1:0] TOP_SLOT = SLOT_W'(N_SYM - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [SYM_W-1:0]  MAX_CLS  = SYM_W'(N_CLASS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_START,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                          state_q, state_d;
    logic [N_SYM-1:0][SYM_W-1:0]     char_q, char_d;
    logic [NSYM_W-1:0]               n_sym_q, n_sym_d;
    logic [FREQ_W-1:0]               tally_q, tally_d;
    logic [TMO_W-1:0]                tmo_q, tmo_d;
    logic [N_CLASS*FREQ_W-1:0]       freq_q, freq_d;
    logic                            freq_valid_q, freq_valid_d;
    logic                            err_sum_q, err_sum_d;
    logic                            err_tmo_q, err_tmo_d;
    logic                            sym_ready_q, sym_ready_d;
    logic                            cnt_nrst_q, cnt_nrst_d;
    logic                            input_over_q, input_over_d;

    logic                            sym_hs;
    logic                            sym_cls;
    logic                            blk_end;
    logic [TMO_W-1:0]                tmo_inc;
    logic                            tmo_hit;
    logic [SLOT_W-1:0]               slot;
    logic [FREQ_W-1:0]               fsum;

    assign sym_hs  = sym_valid & sym_ready_q;
    assign sym_cls = (sym_in <= MAX_CLS);
    assign blk_end = sym_last | (n_sym_q == LAST_N);
    assign tmo_inc = tmo_q + TMO_W'(1);
    assign tmo_hit = (tmo_inc == TMO_LAST);
    // slot 0 lives in the most significant nibble of the character buffer
    assign slot    = TOP_SLOT - n_sym_q[SLOT_W-1:0];

    always_comb begin
        fsum = '0;
        for (int c = 0; c < N_CLASS; c++) begin
            fsum = fsum + cnt_freq[c*FREQ_W +: FREQ_W];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (sym_hs) state_d = sym_last ? S_START : S_FILL;
            S_FILL:  if (sym_hs && blk_end) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (cnt_over) begin
                    state_d = S_HOLD;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD:  if (freq_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        char_d       = char_q;
        n_sym_d      = n_sym_q;
        tally_d      = tally_q;
        tmo_d        = tmo_q;
        freq_d       = freq_q;
        freq_valid_d = freq_valid_q;
        err_sum_d    = err_sum_q;
        err_tmo_d    = err_tmo_q;

        // handshake-facing strobes are registered off the next state
        sym_ready_d  = (state_d == S_IDLE) || (state_d == S_FILL);
        cnt_nrst_d   = (state_d == S_START) || (state_d == S_WAIT) || (state_d == S_HOLD);
        input_over_d = cnt_nrst_d;

        unique case (state_q)
            S_IDLE: begin
                char_d  = {N_SYM{PAD_SYM}};
                tally_d = '0;
                n_sym_d = '0;
                if (sym_hs) begin
                    char_d[N_SYM-1] = sym_in;
                    n_sym_d         = NSYM_W'(1);
                    tally_d         = sym_cls ? FREQ_W'(1) : '0;
                end
            end
            S_FILL: begin
                if (sym_hs) begin
                    char_d[slot] = sym_in;
                    n_sym_d      = n_sym_q + NSYM_W'(1);
                    if (sym_cls) begin
                        tally_d = tally_q + FREQ_W'(1);
                    end
                end
            end
            S_START: begin
                tmo_d = '0;
            end
            S_WAIT: begin
                tmo_d = tmo_inc;
                if (cnt_over) begin
                    freq_d       = cnt_freq;
                    err_sum_d    = (fsum != tally_q);
                    freq_valid_d = 1'b1;
                end else if (tmo_hit) begin
                    err_tmo_d = 1'b1;
                    n_sym_d   = '0;
                end
            end
            S_HOLD: begin
                if (freq_ready) begin
                    freq_valid_d = 1'b0;
                    n_sym_d      = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            char_q       <= {N_SYM{PAD_SYM}};
            n_sym_q      <= '0;
            tally_q      <= '0;
            tmo_q        <= '0;
            freq_q       <= '0;
            freq_valid_q <= 1'b0;
            err_sum_q    <= 1'b0;
            err_tmo_q    <= 1'b0;
            sym_ready_q  <= 1'b0;
            cnt_nrst_q   <= 1'b0;
            input_over_q <= 1'b0;
        end else begin
            char_q       <= char_d;
            n_sym_q      <= n_sym_d;
            tally_q      <= tally_d;
            tmo_q        <= tmo_d;
            freq_q       <= freq_d;
            freq_valid_q <= freq_valid_d;
            err_sum_q    <= err_sum_d;
            err_tmo_q    <= err_tmo_d;
            sym_ready_q  <= sym_ready_d;
            cnt_nrst_q   <= cnt_nrst_d;
            input_over_q <= input_over_d;
        end
    end

    assign sym_ready      = sym_ready_q;
    assign cnt_nRST       = cnt_nrst_q;
    assign cnt_input_over = input_over_q;
    assign cnt_char       = char_q;
    assign freq_out       = freq_q;
    assign freq_valid     = freq_valid_q;
    assign n_sym          = n_sym_q;
    assign busy           = (state_q != S_IDLE);
    assign err_sum        = err_sum_q;
    assign err_timeout    = err_tmo_q;

endmodule
